pcs_receive: RTL and testbench
==============================

# pcs_receive

1000BASE-X PCS receive state machine, IEEE 802.3 Clause 36 style. Sits directly downstream of the synchronizer and its code-group ROM. Consumes decoded code groups plus sync status and produces the GMII-side receive signals `rxd`, `rx_dv`, `rx_er` and `receiving`. It recognises idle, start, end and extension ordered sets, and flags false carrier, early end and invalid groups.

## Interface
Parameters:
- `LOOKAHEAD`, 2: code groups of lookahead used for end-of-packet checks. Fixed at 2; other values are unsupported.

Ports:
- `sync_clk`  in  1  code-group clock; one group per cycle.
- `mr_main_reset`  in  1  asynchronous, active-high reset.
- `sync_status`  in  1  1 = synchronizer has lock.
- `rx_even`  in  1  1 = current group is in an even position.
- `rx_cg_valid`  in  1  1 = group exists in the 8B/10B table (ROM `existence`).
- `rx_k`  in  1  1 = control (K) group.
- `rx_octet`  in  8  decoded octet.
- `rxd`  out  8  received octet.
- `rx_dv`  out  1  data valid.
- `rx_er`  out  1  receive error.
- `receiving`  out  1  carrier / packet in progress.

## Operation
- Group constants:
  - K28.5 = K 0xBC, /S/ = K 0xFB, /T/ = K 0xFD, /R/ = K 0xF7.
  - Config second groups: D21.5 = 0xB5, D2.2 = 0x42.
  - Any D group with `rx_cg_valid`=1 is data.
  - An invalid group (`rx_cg_valid`=0) is /V/.
- Window: 3-entry shift register `cg0` (oldest), `cg1`, `cg2` (newest). Each entry holds {octet, k, valid, even, sync}.
  - Loads every cycle.
  - Resets to /V/ with sync=0.
  - The FSM decides on `cg0`, using `cg1`/`cg2` as lookahead.
- States and transitions (all evaluated on `cg0`; any state with `cg0.sync`=0 goes to LINK_FAILED):
  - LINK_FAILED: outputs 0. If `receiving` was 1 on entry, `rx_er`=1 for exactly one cycle. Exit to WAIT_FOR_K when sync=1.
  - WAIT_FOR_K: K28.5 with even=1 goes to RX_K. Otherwise stay.
  - RX_K: D21.5 or D2.2 goes to WAIT_FOR_K (config, discarded). Other valid D goes to IDLE_D. K or /V/ goes to WAIT_FOR_K.
  - IDLE_D:
    - K28.5 goes to RX_K.
    - /S/ goes to RECEIVE: `rx_dv`=1, `rxd`=0x55, `receiving`=1.
    - Anything else goes to FALSE_CARRIER.
  - FALSE_CARRIER: `rx_er`=1, `rxd`=0x0E, `rx_dv`=0, `receiving`=1. K28.5 with even=1 goes to RX_K with `receiving`=0.
  - RECEIVE, priority order:
    - (a) /T/,/R/,K28.5 in `cg0`,`cg1`,`cg2` goes to TRI_RRI.
    - (b) /T/,/R/,/R/ goes to TRR_EXTEND.
    - (c) K28.5 in `cg0` goes to EARLY_END.
    - (d) valid D: `rxd`=octet, `rx_dv`=1, `rx_er`=0.
    - (e) otherwise (other K or /V/): `rx_dv`=1, `rx_er`=1, `rxd`=0x00, stay in RECEIVE.
  - TRI_RRI: `rx_dv`=0, `rx_er`=0, `receiving`=0. The /R/ cycle keeps these outputs. The next K28.5 goes to RX_K.
  - TRR_EXTEND:
    - Each /R/: `rx_dv`=0, `rx_er`=1, `rxd`=0x0F, `receiving`=1.
    - K28.5 with even=1: `receiving`=0, go to RX_K.
    - Any other group: stay, same outputs.
  - EARLY_END: one cycle of `rx_dv`=0, `rx_er`=1, `rxd`=0x0E, `receiving`=0. The K28.5 is consumed; go to RX_K.
- Outputs are registered. `rxd` holds its last value whenever `rx_dv`=0 and `rx_er`=0.

## Timing
- Reset (asynchronous, immediate):
  - `rxd`=0x00, `rx_dv`=0, `rx_er`=0, `receiving`=0.
  - State LINK_FAILED; window all /V/ with sync=0.
  - The "was receiving" error pulse is suppressed on reset.
- Latency: a group sampled at edge n reaches `cg0` after edge n+2. Its outputs appear after edge n+3, a fixed 3 cycles.
- `sync_status` is delayed with the window, so a link drop takes effect on the same 3-cycle latency as data.
- Reset mid-packet: outputs drop immediately. No `rx_er` pulse.
- Simultaneous events: sync=0 overrides every other condition. In RECEIVE, (a) beats (b), which beats (c).
- After the first /T/ is detected, the window keeps shifting. The lookahead groups are re-examined as `cg0` in the next states, not skipped.

## Test plan
- Reset mid-packet, asserted for 2 cycles -> all outputs 0 immediately; after release with idle input, outputs stay 0.
- Idle (K28.5 D16.2 x4), then /S/, 0x55 x6, 0xD5, 0x01–0x04, then /T/R/K28.5 D16.2 -> `rx_dv`=1 for 12 cycles; `rxd` = 0x55 x7, 0xD5, 0x01–0x04; `rx_er`=0 throughout; `receiving` falls with `rx_dv`.
- Packet ending /T/R/R/R/K28.5(even) -> `rx_dv` falls at /T/; `rx_er`=1 with `rxd`=0x0F for 3 cycles; `receiving` clears at K28.5.
- Idle then D0.0 instead of /S/ -> `rx_er`=1, `rxd`=0x0E, `rx_dv`=0, `receiving`=1 until the next even K28.5.
- Invalid group (`rx_cg_valid`=0) at packet byte 3 -> exactly one cycle of `rx_dv`=1, `rx_er`=1, `rxd`=0x00; the packet continues. Separately, K28.5 mid-packet -> one cycle of EARLY_END (`rx_er`=1, `rxd`=0x0E), then RX_K.
- `sync_status` dropped mid-packet -> 3 cycles later `rx_er`=1 for one cycle, then all outputs 0; no recovery until sync=1 and an even K28.5.

Source files
------------

// File: rtl/pcs_receive_if.sv
// rtl/pcs_receive_if.sv - code-group input and GMII receive output bundle for pcs_receive
interface pcs_receive_if;
  logic       sync_status;
  logic       rx_even;
  logic       rx_cg_valid;
  logic       rx_k;
  logic [7:0] rx_octet;
  logic [7:0] rxd;
  logic       rx_dv;
  logic       rx_er;
  logic       receiving;

  modport master (
    output sync_status, rx_even, rx_cg_valid, rx_k, rx_octet,
    input  rxd, rx_dv, rx_er, receiving
  );

  modport slave (
    input  sync_status, rx_even, rx_cg_valid, rx_k, rx_octet,
    output rxd, rx_dv, rx_er, receiving
  );
endinterface

// File: rtl/pcs_receive.sv
// rtl/pcs_receive.sv - 1000BASE-X PCS receive state machine with 3-group decision window
module pcs_receive #(
  parameter int LOOKAHEAD = 2
) (
  input  logic          sync_clk,
  input  logic          mr_main_reset,
  pcs_receive_if.slave  rx
);

  typedef struct packed {
    logic [7:0] octet;
    logic       k;
    logic       valid;
    logic       even;
    logic       sync;
  } cg_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K_S   = 8'hFB;
  localparam logic [7:0] K_T   = 8'hFD;
  localparam logic [7:0] K_R   = 8'hF7;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;

  localparam logic [3:0] LINK_FAILED   = 4'd0;
  localparam logic [3:0] WAIT_FOR_K    = 4'd1;
  localparam logic [3:0] RX_K          = 4'd2;
  localparam logic [3:0] IDLE_D        = 4'd3;
  localparam logic [3:0] FALSE_CARRIER = 4'd4;
  localparam logic [3:0] RECEIVE       = 4'd5;
  localparam logic [3:0] TRI_RRI       = 4'd6;
  localparam logic [3:0] TRR_EXTEND    = 4'd7;
  localparam logic [3:0] EARLY_END     = 4'd8;

  // win[0] is the group being decided on; higher indices are lookahead
  cg_t        win [LOOKAHEAD+1];
  cg_t        cg_in;
  logic [3:0] state_q, state_d;
  logic [7:0] rxd_q, rxd_d;
  logic       dv_q, dv_d;
  logic       er_q, er_d;
  logic       rcv_q, rcv_d;

  function automatic logic is_ctl(input cg_t g, input logic [7:0] v);
    return g.valid && g.k && (g.octet == v);
  endfunction

  function automatic logic is_data(input cg_t g);
    return g.valid && !g.k;
  endfunction

  assign cg_in = '{octet: rx.rx_octet, k: rx.rx_k, valid: rx.rx_cg_valid,
                   even: rx.rx_even, sync: rx.sync_status};

  // shift the incoming group (and its sync flag) through the decision window
  always_ff @(posedge sync_clk or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      for (int i = 0; i <= LOOKAHEAD; i++) win[i] <= '0;
    end else begin
      for (int i = 0; i < LOOKAHEAD; i++) win[i] <= win[i+1];
      win[LOOKAHEAD] <= cg_in;
    end
  end

  // next state and next outputs from the current state and the window
  always_comb begin
    state_d = state_q;
    rxd_d   = rxd_q;
    dv_d    = 1'b0;
    er_d    = 1'b0;
    rcv_d   = 1'b0;
    if (!win[0].sync) begin
      // loss of lock: one error cycle only if a packet or carrier was in progress
      state_d = LINK_FAILED;
      er_d    = rcv_q;
      rxd_d   = 8'h00;
    end else begin
      case (state_q)
        LINK_FAILED: state_d = WAIT_FOR_K;
        WAIT_FOR_K: begin
          if (is_ctl(win[0], K28_5) && win[0].even) state_d = RX_K;
        end
        // an early end already consumed its K28.5, so it decides like RX_K
        RX_K, EARLY_END: begin
          if (is_data(win[0]) && win[0].octet != D21_5 && win[0].octet != D2_2)
            state_d = IDLE_D;
          else
            state_d = WAIT_FOR_K;
        end
        IDLE_D: begin
          if (is_ctl(win[0], K28_5)) begin
            state_d = RX_K;
          end else if (is_ctl(win[0], K_S)) begin
            state_d = RECEIVE;
            dv_d    = 1'b1;
            rxd_d   = 8'h55;
            rcv_d   = 1'b1;
          end else begin
            state_d = FALSE_CARRIER;
            er_d    = 1'b1;
            rxd_d   = 8'h0E;
            rcv_d   = 1'b1;
          end
        end
        FALSE_CARRIER: begin
          if (is_ctl(win[0], K28_5) && win[0].even) begin
            state_d = RX_K;
          end else begin
            er_d  = 1'b1;
            rxd_d = 8'h0E;
            rcv_d = 1'b1;
          end
        end
        RECEIVE: begin
          if (is_ctl(win[0], K_T) && is_ctl(win[1], K_R) && is_ctl(win[2], K28_5)) begin
            state_d = TRI_RRI;
          end else if (is_ctl(win[0], K_T) && is_ctl(win[1], K_R) && is_ctl(win[2], K_R)) begin
            state_d = TRR_EXTEND;
            rcv_d   = 1'b1;
          end else if (is_ctl(win[0], K28_5)) begin
            state_d = EARLY_END;
            er_d    = 1'b1;
            rxd_d   = 8'h0E;
          end else if (is_data(win[0])) begin
            dv_d  = 1'b1;
            rxd_d = win[0].octet;
            rcv_d = 1'b1;
          end else begin
            dv_d  = 1'b1;
            er_d  = 1'b1;
            rxd_d = 8'h00;
            rcv_d = 1'b1;
          end
        end
        TRI_RRI: begin
          if (is_ctl(win[0], K28_5)) state_d = RX_K;
        end
        TRR_EXTEND: begin
          if (is_ctl(win[0], K28_5) && win[0].even) begin
            state_d = RX_K;
          end else begin
            er_d  = 1'b1;
            rxd_d = 8'h0F;
            rcv_d = 1'b1;
          end
        end
        default: state_d = LINK_FAILED;
      endcase
    end
  end

  // register state and GMII-side outputs
  always_ff @(posedge sync_clk or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state_q <= LINK_FAILED;
      rxd_q   <= 8'h00;
      dv_q    <= 1'b0;
      er_q    <= 1'b0;
      rcv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rxd_q   <= rxd_d;
      dv_q    <= dv_d;
      er_q    <= er_d;
      rcv_q   <= rcv_d;
    end
  end

  assign rx.rxd       = rxd_q;
  assign rx.rx_dv     = dv_q;
  assign rx.rx_er     = er_q;
  assign rx.receiving = rcv_q;

endmodule

// File: tb/tb_pcs_receive.sv
// tb/tb_pcs_receive.sv - directed self-checking bench for pcs_receive
module tb_pcs_receive;
  logic sync_clk = 1'b0;
  logic mr_main_reset = 1'b0;
  logic even_q = 1'b1;
  int   total = 0;
  int   bad = 0;

  typedef struct packed {
    logic       dv;
    logic       er;
    logic       rcv;
    logic       ck;
    logic [7:0] rxd;
  } exp_t;

  exp_t  pend [$];
  string tags [$];

  always #5 sync_clk = ~sync_clk;

  pcs_receive_if bus();

  pcs_receive #(.LOOKAHEAD(2)) dut (
    .sync_clk      (sync_clk),
    .mr_main_reset (mr_main_reset),
    .rx            (bus.slave)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  // drive one group; outputs for it are checked three edges later
  task automatic grp(input string tag, input logic k, input logic [7:0] o, input logic v,
                     input logic s, input logic dv, input logic er, input logic rcv,
                     input int rxd);
    exp_t  e;
    string t;
    bus.rx_k        = k;
    bus.rx_octet    = o;
    bus.rx_cg_valid = v;
    bus.sync_status = s;
    bus.rx_even     = even_q;
    even_q          = ~even_q;
    e.dv  = dv;
    e.er  = er;
    e.rcv = rcv;
    e.ck  = (rxd >= 0);
    e.rxd = (rxd >= 0) ? rxd[7:0] : 8'h00;
    pend.push_back(e);
    tags.push_back(tag);
    @(posedge sync_clk);
    #1;
    if (pend.size() > 3) begin
      e = pend.pop_front();
      t = tags.pop_front();
      check({t, ".dv"},  {7'd0, bus.rx_dv},     {7'd0, e.dv});
      check({t, ".er"},  {7'd0, bus.rx_er},     {7'd0, e.er});
      check({t, ".rcv"}, {7'd0, bus.receiving}, {7'd0, e.rcv});
      if (e.ck) check({t, ".rxd"}, bus.rxd, e.rxd);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      grp("idle_k", 1'b1, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
      grp("idle_d", 1'b0, 8'h50, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    end
  endtask

  task automatic sop(input string tag);
    grp(tag, 1'b1, 8'hFB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 'h55);
  endtask

  task automatic dat(input string tag, input logic [7:0] o);
    grp(tag, 1'b0, o, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, int'(o));
  endtask

  // /T/ /R/ K28.5 D16.2 end; rxd keeps the last data byte
  task automatic end_tri(input logic [7:0] last);
    grp("tri_t", 1'b1, 8'hFD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, int'(last));
    grp("tri_r", 1'b1, 8'hF7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, int'(last));
    grp("tri_k", 1'b1, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    grp("tri_d", 1'b0, 8'h50, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    bus.rx_k        = 1'b1;
    bus.rx_octet    = 8'hBC;
    bus.rx_cg_valid = 1'b1;
    bus.sync_status = 1'b1;
    bus.rx_even     = 1'b1;

    #2 mr_main_reset = 1'b1;
    #1;
    check("rst.dv",  {7'd0, bus.rx_dv},     8'h00);
    check("rst.er",  {7'd0, bus.rx_er},     8'h00);
    check("rst.rcv", {7'd0, bus.receiving}, 8'h00);
    check("rst.rxd", bus.rxd,               8'h00);
    @(posedge sync_clk);
    @(posedge sync_clk);
    #1 mr_main_reset = 1'b0;

    idle(4);

    sop("a_s");
    for (int i = 0; i < 6; i++) dat("a_pre", 8'h55);
    dat("a_sfd", 8'hD5);
    for (int i = 1; i <= 4; i++) dat("a_d", 8'(i));
    end_tri(8'h04);
    idle(1);

    sop("b_s");
    dat("b_d", 8'h01);
    dat("b_d", 8'h02);
    dat("b_d", 8'h03);
    grp("b_t", 1'b1, 8'hFD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 'h03);
    for (int i = 0; i < 3; i++)
      grp("b_r", 1'b1, 8'hF7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 'h0F);
    grp("b_k", 1'b1, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 'h0F);
    grp("b_kd", 1'b0, 8'h50, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle(1);

    grp("fc_d0", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 'h0E);
    grp("fc_d", 1'b0, 8'h50, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 'h0E);
    grp("fc_k", 1'b1, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    grp("fc_kd", 1'b0, 8'h50, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle(1);

    sop("v_s");
    dat("v_d", 8'h11);
    dat("v_d", 8'h22);
    grp("v_bad", 1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 'h00);
    dat("v_d", 8'h44);
    dat("v_d", 8'h66);
    end_tri(8'h66);
    idle(1);

    sop("e_s");
    dat("e_d", 8'hA1);
    dat("e_d", 8'hA2);
    dat("e_d", 8'hA3);
    grp("e_k", 1'b1, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 'h0E);
    grp("e_kd", 1'b0, 8'h50, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle(1);

    idle(1);
    sop("l_s");
    dat("l_d", 8'h01);
    dat("l_d", 8'h02);
    grp("l_drop", 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    grp("l_s0", 1'b1, 8'hFB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 3; i++)
      grp("l_d0", 1'b0, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(2);
    sop("l_rs");
    dat("l_rd", 8'h09);
    end_tri(8'h09);
    idle(1);

    idle(1);
    sop("r_s");
    for (int i = 1; i <= 4; i++) dat("r_d", 8'(i));
    #2 mr_main_reset = 1'b1;
    #1;
    check("mrst.dv",  {7'd0, bus.rx_dv},     8'h00);
    check("mrst.er",  {7'd0, bus.rx_er},     8'h00);
    check("mrst.rcv", {7'd0, bus.receiving}, 8'h00);
    check("mrst.rxd", bus.rxd,               8'h00);
    @(posedge sync_clk);
    @(posedge sync_clk);
    #1 mr_main_reset = 1'b0;
    pend.delete();
    tags.delete();
    even_q = 1'b1;
    idle(3);
    check("post.rxd", bus.rxd, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=%0d exp=0", total);
    $fatal(1, "timeout");
  end
endmodule
